// File: rtl/toe_rx_pkt_fifo.sv
// rtl/toe_rx_pkt_fifo.sv - store-and-forward rx packet FIFO that drops errored or oversize packets
module toe_rx_pkt_fifo #(
    parameter int DataWidth = 32,
    parameter int Depth     = 64,
    localparam int AW       = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DataWidth-1:0] s_tdata_i,
    input  logic                 s_tvalid_i,
    output logic                 s_tready_o,
    input  logic                 s_tuser_i,
    input  logic                 s_tlast_i,
    output logic [DataWidth-1:0] m_tdata_o,
    output logic                 m_tvalid_o,
    input  logic                 m_tready_i,
    output logic                 m_tuser_o,
    output logic                 m_tlast_o,
    output logic [AW:0]          pkt_count_o,
    output logic [15:0]          drop_count_o
);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

    localparam logic [AW:0] DepthPtr = (AW+1)'(Depth);
    localparam logic [AW:0] PtrOne   = (AW+1)'(1);

    logic [DataWidth:0] r_mem [Depth];
    logic [AW:0]        r_wr_commit;
    logic [AW:0]        r_wr_spec;
    logic [AW:0]        r_rd;
    logic [AW:0]        r_pkt_count;
    logic [15:0]        r_drop_count;
    state_t             r_state;
    logic               r_sop;
    logic               r_ready;

    logic               w_accept;
    logic [AW:0]        w_used;
    logic               w_space;
    logic               w_receiving;
    logic               w_bad_last;
    logic               w_wr_en;
    logic               w_drop;
    logic               w_commit;
    logic [AW:0]        w_wr_next;
    logic               w_m_valid;
    logic [DataWidth:0] w_rd_entry;
    logic               w_rd_fire;
    logic               w_rd_last;

    // Space is judged against the registered read pointer only, so a read in
    // the same cycle never lets a write through.
    assign w_accept    = s_tvalid_i & r_ready;
    assign w_used      = r_wr_spec - r_rd;
    assign w_space     = w_used < DepthPtr;
    assign w_receiving = (r_state != S_DROP);
    assign w_bad_last  = s_tlast_i & s_tuser_i;
    assign w_wr_en     = w_accept & w_receiving & w_space & ~w_bad_last;
    assign w_drop      = w_accept & w_receiving & (~w_space | w_bad_last);
    assign w_commit    = w_wr_en & s_tlast_i;
    assign w_wr_next   = r_wr_spec + PtrOne;

    assign w_m_valid   = (r_rd != r_wr_commit);
    assign w_rd_entry  = r_mem[r_rd[AW-1:0]];
    assign w_rd_fire   = w_m_valid & m_tready_i;
    assign w_rd_last   = w_rd_fire & w_rd_entry[DataWidth];

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_spec[AW-1:0]] <= {s_tlast_i, s_tdata_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_commit  <= '0;
            r_wr_spec    <= '0;
            r_rd         <= '0;
            r_pkt_count  <= '0;
            r_drop_count <= '0;
            r_state      <= S_IDLE;
            r_sop        <= 1'b1;
            r_ready      <= 1'b0;
        end else begin
            r_ready <= 1'b1;

            if (w_wr_en) begin
                r_wr_spec <= w_wr_next;
                if (s_tlast_i) begin
                    r_wr_commit <= w_wr_next;
                end
            end

            // Rewind the speculative pointer; only the first drop of a packet counts.
            if (w_drop) begin
                r_wr_spec <= r_wr_commit;
                if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 16'd1;
                end
            end

            case (r_state)
                S_IDLE, S_RECV: begin
                    if (w_accept) begin
                        r_state <= s_tlast_i ? S_IDLE : (w_drop ? S_DROP : S_RECV);
                    end
                end
                S_DROP: begin
                    if (w_accept && s_tlast_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_rd_fire) begin
                r_rd  <= r_rd + PtrOne;
                r_sop <= w_rd_entry[DataWidth];
            end

            case ({w_commit, w_rd_last})
                2'b10:   r_pkt_count <= r_pkt_count + PtrOne;
                2'b01:   r_pkt_count <= r_pkt_count - PtrOne;
                default: r_pkt_count <= r_pkt_count;
            endcase
        end
    end

    assign s_tready_o   = r_ready;
    assign m_tvalid_o   = w_m_valid;
    assign m_tdata_o    = w_rd_entry[DataWidth-1:0];
    assign m_tlast_o    = w_m_valid & w_rd_entry[DataWidth];
    assign m_tuser_o    = r_sop & w_m_valid;
    assign pkt_count_o  = r_pkt_count;
    assign drop_count_o = r_drop_count;

endmodule

// File: tb/tb_toe_rx_pkt_fifo.sv
// tb/tb_toe_rx_pkt_fifo.sv - directed self-checking bench for toe_rx_pkt_fifo
module tb_toe_rx_pkt_fifo;

    localparam int DW = 32;
    localparam int DEPTH = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tuser;
    logic          s_tlast;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tuser;
    logic          m_tlast;
    logic [AW:0]   pkt_count;
    logic [15:0]   drop_count;

    int checks = 0;
    int errors = 0;
    int exp_drop = 0;

    // {tuser, tlast, data} of each beat transferred downstream
    logic [DW+1:0] q_out[$];

    always #5 clk = ~clk;

    toe_rx_pkt_fifo #(.DataWidth(DW), .Depth(DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .s_tdata_i   (s_tdata),
        .s_tvalid_i  (s_tvalid),
        .s_tready_o  (s_tready),
        .s_tuser_i   (s_tuser),
        .s_tlast_i   (s_tlast),
        .m_tdata_o   (m_tdata),
        .m_tvalid_o  (m_tvalid),
        .m_tready_i  (m_tready),
        .m_tuser_o   (m_tuser),
        .m_tlast_o   (m_tlast),
        .pkt_count_o (pkt_count),
        .drop_count_o(drop_count)
    );

    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) q_out.push_back({m_tuser, m_tlast, m_tdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic user);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = user;
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic send_pkt(input logic [DW-1:0] base, input int len, input logic user);
        for (int i = 0; i < len; i++) send_beat(base + DW'(i), (i == len - 1), user);
    endtask

    task automatic wait_out(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (q_out.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_tvalid = 0; s_tdata = 0; s_tlast = 0; s_tuser = 0; m_tready = 0;
        repeat (3) tick();
        checks++;
        if ({s_tready, m_tvalid, m_tuser, m_tlast} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {s_tready, m_tvalid, m_tuser, m_tlast});
        end
        checks++;
        if (pkt_count !== 0 || drop_count !== 0) begin
            errors++; $display("FAIL reset_counts got pkt=%0d drop=%0d want 0 0", pkt_count, drop_count);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (s_tready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset got %b want 1", s_tready);
        end
    endtask

    task automatic test_basic();
        bit ok;
        logic [DW+1:0] exp;
        m_tready = 1'b1;
        q_out.delete();
        for (int i = 0; i < 3; i++) send_beat(32'hA0 + DW'(i), 1'b0, 1'b0);
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++; $display("FAIL basic_no_early_valid got %b want 0", m_tvalid);
        end
        send_beat(32'hA3, 1'b1, 1'b0);
        checks++;
        if ({m_tvalid, m_tuser, m_tdata} !== {2'b11, 32'hA0} || pkt_count !== 1) begin
            errors++; $display("FAIL basic_latency got v=%b u=%b d=%h pkt=%0d want 1 1 a0 1",
                               m_tvalid, m_tuser, m_tdata, pkt_count);
        end
        wait_out(4, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL basic_timeout got %0d beats want 4", q_out.size());
        end
        for (int i = 0; i < 4 && i < q_out.size(); i++) begin
            exp = {(i == 0), (i == 3), 32'hA0 + DW'(i)};
            checks++;
            if (q_out[i] !== exp) begin
                errors++; $display("FAIL basic_beat%0d got %h want %h", i, q_out[i], exp);
            end
        end
        checks++;
        if (pkt_count !== 0) begin
            errors++; $display("FAIL basic_pkt_drain got %0d want 0", pkt_count);
        end
    endtask

    task automatic test_drop_err();
        bit ok;
        logic [DW+1:0] exp;
        m_tready = 1'b1;
        q_out.delete();
        send_pkt(32'hB0, 3, 1'b1);
        exp_drop++;
        send_pkt(32'hC0, 2, 1'b0);
        wait_out(2, ok);
        repeat (5) tick();
        checks++;
        if (!ok || q_out.size() != 2) begin
            errors++; $display("FAIL err_beats got %0d want 2", q_out.size());
        end
        for (int i = 0; i < 2 && i < q_out.size(); i++) begin
            exp = {(i == 0), (i == 1), 32'hC0 + DW'(i)};
            checks++;
            if (q_out[i] !== exp) begin
                errors++; $display("FAIL err_beat%0d got %h want %h", i, q_out[i], exp);
            end
        end
        checks++;
        if (drop_count !== 16'(exp_drop)) begin
            errors++; $display("FAIL err_drop got %0d want %0d", drop_count, exp_drop);
        end
    endtask

    task automatic test_oversize();
        bit ok;
        int bad = 0;
        m_tready = 1'b0;
        q_out.delete();
        send_pkt(32'h1000, DEPTH + 1, 1'b0);
        exp_drop++;
        checks++;
        if (m_tvalid !== 1'b0 || drop_count !== 16'(exp_drop)) begin
            errors++; $display("FAIL oversize_drop got v=%b drop=%0d want 0 %0d", m_tvalid, drop_count, exp_drop);
        end
        send_pkt(32'h2000, DEPTH, 1'b0);
        checks++;
        if (pkt_count !== 1 || m_tvalid !== 1'b1) begin
            errors++; $display("FAIL full_pkt_commit got pkt=%0d v=%b want 1 1", pkt_count, m_tvalid);
        end
        m_tready = 1'b1;
        wait_out(DEPTH, ok);
        for (int i = 0; i < q_out.size(); i++)
            if (q_out[i] !== {(i == 0), (i == DEPTH - 1), 32'h2000 + DW'(i)}) bad++;
        checks++;
        if (!ok || bad != 0 || q_out.size() != DEPTH) begin
            errors++; $display("FAIL full_pkt_data got %0d beats %0d bad want %0d beats 0 bad", q_out.size(), bad, DEPTH);
        end
    endtask

    task automatic test_full();
        bit ok;
        int bad = 0;
        logic [DW+1:0] exp;
        m_tready = 1'b0;
        q_out.delete();
        send_pkt(32'h3000, 32, 1'b0);
        send_pkt(32'h4000, 32, 1'b0);
        checks++;
        if (pkt_count !== 2) begin
            errors++; $display("FAIL full_pkts got %0d want 2", pkt_count);
        end
        m_tready = 1'b1;
        send_pkt(32'h5000, 4, 1'b0);
        exp_drop++;
        wait_out(DEPTH, ok);
        repeat (5) tick();
        for (int i = 0; i < q_out.size(); i++) begin
            exp = {(i % 32 == 0), (i % 32 == 31), ((i < 32) ? 32'h3000 : 32'h4000 - 32) + DW'(i)};
            if (q_out[i] !== exp) bad++;
        end
        checks++;
        if (!ok || bad != 0 || q_out.size() != DEPTH) begin
            errors++; $display("FAIL full_data got %0d beats %0d bad want %0d beats 0 bad", q_out.size(), bad, DEPTH);
        end
        checks++;
        if (drop_count !== 16'(exp_drop) || pkt_count !== 0) begin
            errors++; $display("FAIL full_counts got drop=%0d pkt=%0d want %0d 0", drop_count, pkt_count, exp_drop);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] d;
        logic l, v, u;
        logic [DW+1:0] exp;
        m_tready = 1'b0;
        q_out.delete();
        send_pkt(32'h6000, 5, 1'b0);
        for (int k = 0; k < 20 && q_out.size() < 5; k++) begin
            m_tready = 1'b0;
            d = m_tdata; l = m_tlast; v = m_tvalid; u = m_tuser;
            tick();
            checks++;
            if ({m_tvalid, m_tuser, m_tlast, m_tdata} !== {v, u, l, d} || v !== 1'b1) begin
                errors++; $display("FAIL stall_hold%0d got %b%b%b %h want 1%b%b %h", k, m_tvalid, m_tuser, m_tlast, m_tdata, u, l, d);
            end
            m_tready = 1'b1;
            tick();
        end
        checks++;
        if (q_out.size() != 5) begin
            errors++; $display("FAIL stall_count got %0d want 5", q_out.size());
        end
        for (int i = 0; i < 5 && i < q_out.size(); i++) begin
            exp = {(i == 0), (i == 4), 32'h6000 + DW'(i)};
            checks++;
            if (q_out[i] !== exp) begin
                errors++; $display("FAIL stall_beat%0d got %h want %h", i, q_out[i], exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [DW+1:0] exp;
        m_tready = 1'b0;
        send_pkt(32'h7000, 2, 1'b0);
        send_beat(32'h8000, 1'b0, 1'b0);
        send_beat(32'h8001, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || m_tuser !== 1'b0 || pkt_count !== 0 || drop_count !== 0) begin
            errors++; $display("FAIL midreset got v=%b u=%b pkt=%0d drop=%0d want 0 0 0 0", m_tvalid, m_tuser, pkt_count, drop_count);
        end
        tick();
        rst_n = 1'b1;
        tick();
        m_tready = 1'b1;
        q_out.delete();
        send_pkt(32'h9000, 3, 1'b0);
        wait_out(3, ok);
        repeat (3) tick();
        checks++;
        if (!ok || q_out.size() != 3) begin
            errors++; $display("FAIL midreset_beats got %0d want 3", q_out.size());
        end
        for (int i = 0; i < 3 && i < q_out.size(); i++) begin
            exp = {(i == 0), (i == 2), 32'h9000 + DW'(i)};
            checks++;
            if (q_out[i] !== exp) begin
                errors++; $display("FAIL midreset_beat%0d got %h want %h", i, q_out[i], exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop_err();
        test_oversize();
        test_full();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/toe_rx_pkt_fifo.md
TOE_RX_PKT_FIFO -- requirements
Module: toe_rx_pkt_fifo

Store-and-forward packet FIFO between the ToE receive stream and the DMA controller read-stream input; drops errored or oversize packets.

Interface
REQ-001 Parameter DataWidth, default 32 (top_pkg::AXI_DW), sets the stream data width.
REQ-002 Parameter Depth, default 64, sets the FIFO entries; SHALL be a power of two >= 4; AW = log2(Depth).
REQ-003 clk_i  in  1  clock; all state SHALL update on its rising edge.
REQ-004 rst_ni  in  1  reset; asynchronous, active-low.
REQ-005 s_tdata_i  in  DataWidth  upstream (ToE) beat data.
REQ-006 s_tvalid_i  in  1  upstream beat valid.
REQ-007 s_tready_o  out  1  upstream ready; SHALL be constant 1 out of reset (the block never backpressures and drops on overflow instead).
REQ-008 s_tuser_i  in  1  error flag, sampled only on the tlast beat.
REQ-009 s_tlast_i  in  1  last beat of packet.
REQ-010 m_tdata_o  out  DataWidth  beat data to the DMA reader.
REQ-011 m_tvalid_o  out  1  downstream beat valid.
REQ-012 m_tready_i  in  1  downstream ready.
REQ-013 m_tuser_o  out  1  start-of-packet; high on the first beat of each packet.
REQ-014 m_tlast_o  out  1  last beat of packet.
REQ-015 pkt_count_o  out  AW+1  number of committed packets not yet fully read.
REQ-016 drop_count_o  out  16  dropped packets, saturating at 16'hFFFF.

Function
REQ-017 Storage SHALL be a Depth x (DataWidth+1) array holding data plus the tlast bit.
REQ-018 Pointers SHALL be AW+1 bits: wr_commit, wr_spec and rd; all wrap modulo 2*Depth.
REQ-019 A beat is accepted when s_tvalid_i=1; it is written at wr_spec, which then increments, unless the beat is dropped.
REQ-020 The write FSM SHALL have states IDLE, RECV and DROP; reset state IDLE.
REQ-021 IDLE or RECV, accepted beat without tlast, space available -> write the beat; next state RECV.
REQ-022 IDLE or RECV, accepted tlast beat with tuser=0 and space available -> write the beat, set wr_commit to the new wr_spec; next state IDLE.
REQ-023 IDLE or RECV, accepted tlast beat with tuser=1 -> do not write, set wr_spec to wr_commit, increment drop_count; next state IDLE.
REQ-024 Space available SHALL mean (wr_spec - rd) < Depth, evaluated with the registered rd; a same-cycle read SHALL NOT free space for that cycle's write.
REQ-025 Overflow (beat accepted with no space, IDLE or RECV) -> do not write, set wr_spec to wr_commit, increment drop_count; next state DROP, or IDLE if that beat has tlast.
REQ-026 DROP: discard all beats; on an accepted tlast beat -> IDLE; drop_count SHALL NOT be incremented again for the same packet.
REQ-027 A packet longer than Depth beats SHALL always be dropped; committed data SHALL never be overwritten.
REQ-028 m_tvalid_o SHALL be (rd != wr_commit); m_tdata_o and m_tlast_o SHALL be combinational reads of entry rd.
REQ-029 Latency: a packet whose tlast beat is accepted in cycle N SHALL present m_tvalid_o=1 in cycle N+1.
REQ-030 rd SHALL increment on m_tvalid_o & m_tready_i; m_tdata_o, m_tlast_o and m_tvalid_o SHALL remain stable while m_tvalid_o=1 and m_tready_i=0.
REQ-031 A sop flag SHALL be set at reset and after each transferred tlast beat, and cleared after any other transferred beat; m_tuser_o = sop & m_tvalid_o.
REQ-032 pkt_count_o SHALL increment on a commit and decrement on a transferred tlast beat; both in one cycle -> unchanged.
REQ-033 A commit and a read SHALL be permitted in the same cycle, including when the FIFO is exactly full.

Reset
REQ-034 Asserting rst_ni SHALL immediately clear all pointers, pkt_count_o, drop_count_o and sop=1, and put the FSM in IDLE; m_tvalid_o=0, m_tuser_o=0, m_tlast_o=X-free (0).
REQ-035 Reset mid-packet SHALL discard the partial packet; array contents need not be reset.
REQ-036 s_tready_o SHALL be 0 while rst_ni=0 and 1 from the first cycle after release.

Verification
REQ-037 4-beat packet 0xA0..0xA3, tuser=0, m_tready=1 -> m_tvalid rises the cycle after tlast; beats A0..A3 in order; m_tuser=1 on A0 only; m_tlast=1 on A3; pkt_count 1 -> 0.
REQ-038 3-beat packet with tuser=1 on tlast, then a good 2-beat packet -> only the 2-beat packet is output; drop_count=1.
REQ-039 Depth=64, m_tready=0, 65-beat packet -> no output; drop_count=1; a following 64-beat packet is output intact.
REQ-040 Two 32-beat packets fill the FIFO; then m_tready=1 while a third packet streams in -> the third is dropped at its first beat (same-cycle read frees no space); drop_count=1; the first two are output intact.
REQ-041 Packet streaming out with m_tready toggling every cycle -> outputs hold while stalled; no beat is lost or duplicated.
REQ-042 rst_ni pulsed low mid-packet with one committed packet queued -> m_tvalid=0 and pkt_count=0 immediately; the next packet is output with m_tuser=1 on its first beat.
